// File: rtl/img_arbiter_nch.sv
// img_arbiter_nch: N-channel stream arbiter that multiplexes slave processing
// units onto one registered master-side stream feeding the output FIFO.
// Grants are held for bounded bursts of up to MAX_BURST beats, with one IDLE
// cycle between consecutive grants.
// Optional feature macro: ARB_RR_EN
//   defined   -> round-robin arbitration starting at a rotating pointer
//   undefined -> fixed priority, lowest channel index wins
module img_arbiter_nch #(
  parameter int N_SLV     = 4,
  parameter int DW        = 32,
  parameter int PW        = 8,
  parameter int MW        = 2,
  parameter int MAX_BURST = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [N_SLV*MW-1:0]        slv_mode,
  input  logic [N_SLV-1:0]           slv_data_valid,
  input  logic [N_SLV*DW-1:0]        slv_data,
  input  logic [N_SLV*PW-1:0]        slv_proc_val,
  output logic [N_SLV-1:0]           slv_ready,
  input  logic                       fifo_full,
  input  logic                       mstr_cmplt,
  output logic [MW-1:0]              slvx_mode,
  output logic [DW-1:0]              slvx_data,
  output logic [PW-1:0]              slvx_proc_val,
  output logic                       slvx_data_valid,
  output logic [$clog2(N_SLV)-1:0]   slvx_grant_id
);

  localparam int IW = $clog2(N_SLV);
  localparam int CW = $clog2(MAX_BURST + 1);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  state_t         state_q, state_d;
  logic [IW-1:0]  owner_q, owner_d;
  logic [CW-1:0]  beat_cnt_q, beat_cnt_d;
  logic [MW-1:0]  slvx_mode_q, slvx_mode_d;
  logic [DW-1:0]  slvx_data_q, slvx_data_d;
  logic [PW-1:0]  slvx_proc_val_q, slvx_proc_val_d;
  logic           slvx_data_valid_q, slvx_data_valid_d;

  logic [N_SLV-1:0] req;
  logic             any_req;
  logic [IW-1:0]    win;
  logic             stall;
  logic [MW-1:0]    own_mode;
  logic [DW-1:0]    own_data;
  logic [PW-1:0]    own_proc_val;
  logic             own_valid;
  logic             own_active;
  logic             transfer;
  logic             leave;

`ifdef ARB_RR_EN
  logic [IW-1:0]    rr_ptr_q, rr_ptr_d;
  logic [IW-1:0]    next_owner;
`endif

  assign stall        = fifo_full | mstr_cmplt;
  assign own_mode     = slv_mode[owner_q*MW +: MW];
  assign own_data     = slv_data[owner_q*DW +: DW];
  assign own_proc_val = slv_proc_val[owner_q*PW +: PW];
  assign own_valid    = slv_data_valid[owner_q];
  assign own_active   = (own_mode != '0);
  assign any_req      = |req;

  // A channel requests when it is active (nonzero mode) and has a beat ready
  always_comb begin
    req = '0;
    for (int i = 0; i < N_SLV; i++) begin
      req[i] = (slv_mode[i*MW +: MW] != '0) && slv_data_valid[i];
    end
  end

`ifdef ARB_RR_EN
  // Round-robin: first requester at or above the pointer, wrapping to zero
  always_comb begin
    logic found;
    win   = '0;
    found = 1'b0;
    for (int k = 0; k < N_SLV; k++) begin
      if (!found && req[(int'(rr_ptr_q) + k) % N_SLV]) begin
        win   = IW'((int'(rr_ptr_q) + k) % N_SLV);
        found = 1'b1;
      end
    end
  end

  assign next_owner = (owner_q == IW'(N_SLV - 1)) ? '0 : owner_q + 1'b1;
`else
  // Fixed priority: the lowest-index requester wins
  always_comb begin
    win = '0;
    for (int k = N_SLV - 1; k >= 0; k--) begin
      if (req[k]) begin
        win = IW'(k);
      end
    end
  end
`endif

  // Only the owner sees ready, and only while it is active and nothing stalls
  always_comb begin
    slv_ready = '0;
    if ((state_q == BURST) && !stall && own_active) begin
      slv_ready[owner_q] = 1'b1;
    end
  end

  assign transfer = (state_q == BURST) && !stall && own_active && own_valid;

  // Next-state logic: grant from IDLE, count beats and decide when a burst ends
  always_comb begin
    state_d           = state_q;
    owner_d           = owner_q;
    beat_cnt_d        = beat_cnt_q;
    slvx_mode_d       = slvx_mode_q;
    slvx_data_d       = slvx_data_q;
    slvx_proc_val_d   = slvx_proc_val_q;
    slvx_data_valid_d = 1'b0;
    leave             = 1'b0;
`ifdef ARB_RR_EN
    rr_ptr_d          = rr_ptr_q;
`endif
    case (state_q)
      IDLE: begin
        if (any_req && !stall) begin
          owner_d    = win;
          beat_cnt_d = '0;
          state_d    = BURST;
        end
      end
      BURST: begin
        if (mstr_cmplt || !own_active) begin
          leave = 1'b1;
        end else if (transfer) begin
          slvx_mode_d       = own_mode;
          slvx_data_d       = own_data;
          slvx_proc_val_d   = own_proc_val;
          slvx_data_valid_d = 1'b1;
          if (beat_cnt_q == CW'(MAX_BURST - 1)) begin
            leave = 1'b1;
          end else begin
            beat_cnt_d = beat_cnt_q + 1'b1;
          end
        end
        if (leave) begin
          state_d = IDLE;
`ifdef ARB_RR_EN
          rr_ptr_d = next_owner;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset clears everything including a pending pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q           <= IDLE;
      owner_q           <= '0;
      beat_cnt_q        <= '0;
      slvx_mode_q       <= '0;
      slvx_data_q       <= '0;
      slvx_proc_val_q   <= '0;
      slvx_data_valid_q <= 1'b0;
`ifdef ARB_RR_EN
      rr_ptr_q          <= '0;
`endif
    end else begin
      state_q           <= state_d;
      owner_q           <= owner_d;
      beat_cnt_q        <= beat_cnt_d;
      slvx_mode_q       <= slvx_mode_d;
      slvx_data_q       <= slvx_data_d;
      slvx_proc_val_q   <= slvx_proc_val_d;
      slvx_data_valid_q <= slvx_data_valid_d;
`ifdef ARB_RR_EN
      rr_ptr_q          <= rr_ptr_d;
`endif
    end
  end

  assign slvx_mode       = slvx_mode_q;
  assign slvx_data       = slvx_data_q;
  assign slvx_proc_val   = slvx_proc_val_q;
  assign slvx_data_valid = slvx_data_valid_q;
  assign slvx_grant_id   = owner_q;

endmodule

// File: tb/tb_img_arbiter_nch.sv
// Testbench for img_arbiter_nch: directed scenarios with a scoreboard of
// expected output beats and cycle-exact checks on slv_ready / grant id.
module tb_img_arbiter_nch;

  localparam int N_SLV     = 4;
  localparam int DW        = 32;
  localparam int PW        = 8;
  localparam int MW        = 2;
  localparam int MAX_BURST = 4;
  localparam int IW        = 2;

  typedef struct packed {
    logic [MW-1:0] mode;
    logic [DW-1:0] data;
    logic [PW-1:0] pv;
    logic [IW-1:0] gid;
  } beat_t;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic [N_SLV*MW-1:0] slv_mode = '0;
  logic [N_SLV-1:0]    slv_data_valid = '0;
  logic [N_SLV*DW-1:0] slv_data = '0;
  logic [N_SLV*PW-1:0] slv_proc_val = '0;
  logic [N_SLV-1:0]    slv_ready;
  logic                fifo_full = 1'b0;
  logic                mstr_cmplt = 1'b0;
  logic [MW-1:0]       slvx_mode;
  logic [DW-1:0]       slvx_data;
  logic [PW-1:0]       slvx_proc_val;
  logic                slvx_data_valid;
  logic [IW-1:0]       slvx_grant_id;

  int checks = 0;
  int failures = 0;
  beat_t exp_q[$];
  logic [DW-1:0] base [N_SLV];

  img_arbiter_nch #(
    .N_SLV(N_SLV), .DW(DW), .PW(PW), .MW(MW), .MAX_BURST(MAX_BURST)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .slv_mode(slv_mode),
    .slv_data_valid(slv_data_valid),
    .slv_data(slv_data),
    .slv_proc_val(slv_proc_val),
    .slv_ready(slv_ready),
    .fifo_full(fifo_full),
    .mstr_cmplt(mstr_cmplt),
    .slvx_mode(slvx_mode),
    .slvx_data(slvx_data),
    .slvx_proc_val(slvx_proc_val),
    .slvx_data_valid(slvx_data_valid),
    .slvx_grant_id(slvx_grant_id)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input int ch, input logic [MW-1:0] mode, input logic valid);
    slv_mode[ch*MW +: MW] = mode;
    slv_data_valid[ch]    = valid;
  endtask

  task automatic pushBeats(input logic [MW-1:0] mode, input logic [DW-1:0] first,
                           input int n, input logic [IW-1:0] gid);
    beat_t b;
    logic [DW-1:0] d;
    for (int i = 0; i < n; i++) begin
      d      = first + DW'(i);
      b.mode = mode;
      b.data = d;
      b.pv   = d[7:0] ^ 8'hFF;
      b.gid  = gid;
      exp_q.push_back(b);
    end
  endtask

  task automatic resetDut();
    rst_n          = 1'b0;
    slv_mode       = '0;
    slv_data_valid = '0;
    fifo_full      = 1'b0;
    mstr_cmplt     = 1'b0;
    step(3);
    rst_n = 1'b1;
    step(1);
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, " valid"}, 64'(slvx_data_valid), 64'h0);
    checkOutput({tag, " data"},  64'(slvx_data),       64'h0);
    checkOutput({tag, " mode"},  64'(slvx_mode),       64'h0);
    checkOutput({tag, " pv"},    64'(slvx_proc_val),   64'h0);
    checkOutput({tag, " gid"},   64'(slvx_grant_id),   64'h0);
    checkOutput({tag, " ready"}, 64'(slv_ready),       64'h0);
  endtask

  // Slave models: present base+beats_sent, advance only on an accepted beat
  initial begin
    logic [N_SLV-1:0] fire;
    logic [DW-1:0]    sent [N_SLV];
    logic [DW-1:0]    d;
    for (int i = 0; i < N_SLV; i++) begin
      sent[i] = '0;
      base[i] = '0;
    end
    forever begin
      @(negedge clk);
      fire = slv_ready & slv_data_valid;
      @(posedge clk);
      #1;
      for (int i = 0; i < N_SLV; i++) begin
        if (!rst_n) sent[i] = '0;
        else if (fire[i]) sent[i] = sent[i] + 1;
        d = base[i] + sent[i];
        slv_data[i*DW +: DW]     = d;
        slv_proc_val[i*PW +: PW] = d[7:0] ^ 8'hFF;
      end
    end
  end

  // Monitor: every output pulse must match the head of the expected queue
  initial begin
    beat_t e;
    beat_t a;
    forever begin
      @(negedge clk);
      if (rst_n && slvx_data_valid) begin
        a = '{mode: slvx_mode, data: slvx_data, pv: slvx_proc_val, gid: slvx_grant_id};
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("[TB] FAIL unexpected beat: got %0h expected none", a);
        end else begin
          e = exp_q.pop_front();
          if (a !== e) begin
            failures++;
            $display("[TB] FAIL beat: got mode=%0h data=%0h pv=%0h gid=%0h expected mode=%0h data=%0h pv=%0h gid=%0h",
                     a.mode, a.data, a.pv, a.gid, e.mode, e.data, e.pv, e.gid);
          end
        end
      end
    end
  end

  initial begin
    // Reset state
    rst_n = 1'b0;
    step(2);
    checkResetOutputs("reset");
    rst_n = 1'b1;

    // Single channel: two bursts of 4 then 2 beats, one IDLE cycle between
    $display("[TB] single channel");
    base[2] = 32'hA0;
    resetDut();
    pushBeats(2'd1, 32'hA0, 6, 2'd2);
    applyStimulus(2, 2'd1, 1'b1);
    step(1);
    checkOutput("single grant ready", 64'(slv_ready), 64'b0100);
    checkOutput("single grant id", 64'(slvx_grant_id), 64'd2);
    step(4);
    checkOutput("single gap ready", 64'(slv_ready), 64'b0000);
    step(1);
    checkOutput("single regrant ready", 64'(slv_ready), 64'b0100);
    step(2);
    applyStimulus(2, 2'd0, 1'b0);
    step(3);

    // Two competing channels
    base[0] = 32'h100;
    base[3] = 32'h300;
    resetDut();
`ifdef ARB_RR_EN
    $display("[TB] round robin");
    pushBeats(2'd1, 32'h100, 4, 2'd0);
    pushBeats(2'd2, 32'h300, 4, 2'd3);
    pushBeats(2'd1, 32'h104, 4, 2'd0);
    pushBeats(2'd2, 32'h304, 4, 2'd3);
    applyStimulus(0, 2'd1, 1'b1);
    applyStimulus(3, 2'd2, 1'b1);
    step(6);
    checkOutput("rr second grant", 64'(slv_ready), 64'b1000);
    step(5);
    checkOutput("rr third grant", 64'(slv_ready), 64'b0001);
    step(5);
    checkOutput("rr fourth grant", 64'(slv_ready), 64'b1000);
    step(4);
    applyStimulus(0, 2'd0, 1'b0);
    applyStimulus(3, 2'd0, 1'b0);
    step(2);
`else
    $display("[TB] fixed priority");
    pushBeats(2'd1, 32'h100, 9, 2'd0);
    pushBeats(2'd2, 32'h300, 4, 2'd3);
    applyStimulus(0, 2'd1, 1'b1);
    applyStimulus(3, 2'd2, 1'b1);
    step(6);
    checkOutput("fp regrant ch0", 64'(slv_ready), 64'b0001);
    checkOutput("fp regrant id", 64'(slvx_grant_id), 64'd0);
    step(6);
    applyStimulus(0, 2'd0, 1'b0);
    step(1);
    checkOutput("fp handover idle", 64'(slv_ready), 64'b0000);
    step(1);
    checkOutput("fp handover ready", 64'(slv_ready), 64'b1000);
    checkOutput("fp handover id", 64'(slvx_grant_id), 64'd3);
    step(4);
    applyStimulus(3, 2'd0, 1'b0);
    step(2);
`endif

    // Backpressure: fifo_full for 3 cycles mid-burst
    $display("[TB] backpressure");
    base[1] = 32'h11;
    resetDut();
    pushBeats(2'd3, 32'h11, 4, 2'd1);
    applyStimulus(1, 2'd3, 1'b1);
    step(3);
    fifo_full = 1'b1;
    #1;
    checkOutput("bp ready drop", 64'(slv_ready), 64'b0000);
    step(1);
    checkOutput("bp ready low 2", 64'(slv_ready), 64'b0000);
    checkOutput("bp no pulse 2", 64'(slvx_data_valid), 64'h0);
    step(1);
    checkOutput("bp ready low 3", 64'(slv_ready), 64'b0000);
    checkOutput("bp no pulse 3", 64'(slvx_data_valid), 64'h0);
    step(1);
    fifo_full = 1'b0;
    #1;
    checkOutput("bp resume ready", 64'(slv_ready), 64'b0010);
    step(2);
    checkOutput("bp burst end", 64'(slv_ready), 64'b0000);
    applyStimulus(1, 2'd0, 1'b0);
    step(2);

    // Abort via mstr_cmplt during ch1 burst, then ch2 is granted
    $display("[TB] abort");
    base[1] = 32'h50;
    base[2] = 32'h60;
    resetDut();
    pushBeats(2'd1, 32'h50, 2, 2'd1);
    pushBeats(2'd2, 32'h60, 4, 2'd2);
    applyStimulus(1, 2'd1, 1'b1);
    applyStimulus(2, 2'd2, 1'b1);
    step(3);
    mstr_cmplt = 1'b1;
    #1;
    checkOutput("abort ready drop", 64'(slv_ready), 64'b0000);
    step(1);
    checkOutput("abort no pulse", 64'(slvx_data_valid), 64'h0);
    applyStimulus(1, 2'd0, 1'b0);
    step(1);
    checkOutput("abort no grant ready", 64'(slv_ready), 64'b0000);
    checkOutput("abort no grant id", 64'(slvx_grant_id), 64'd1);
    step(1);
    mstr_cmplt = 1'b0;
    step(1);
    checkOutput("abort ch2 ready", 64'(slv_ready), 64'b0100);
    checkOutput("abort ch2 id", 64'(slvx_grant_id), 64'd2);
    step(4);
    applyStimulus(2, 2'd0, 1'b0);
    step(2);

    // Reset mid-burst with ch1 streaming; next grant starts from ch0
    $display("[TB] reset mid-burst");
    base[1] = 32'h70;
    resetDut();
    pushBeats(2'd1, 32'h70, 1, 2'd1);
    applyStimulus(1, 2'd1, 1'b1);
    step(3);
    rst_n = 1'b0;
    #1;
    checkResetOutputs("midreset");
    base[0] = 32'h80;
    applyStimulus(0, 2'd1, 1'b1);
    pushBeats(2'd1, 32'h80, 4, 2'd0);
    step(3);
    rst_n = 1'b1;
    step(1);
    checkOutput("post reset ready", 64'(slv_ready), 64'b0001);
    checkOutput("post reset id", 64'(slvx_grant_id), 64'd0);
    step(4);
    applyStimulus(0, 2'd0, 1'b0);
    applyStimulus(1, 2'd0, 1'b0);
    step(3);

    checkOutput("scoreboard drained", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
